timer_apb_regs: RTL
===================

# timer_apb_regs

APB register front-end for the 64-bit system timer: the host-side end of the counter's load and readback path. It decodes APB transfers and drives the counter's control inputs: enable, clear pulse, halt request, and the TDR0/TDR1 load strobes with data. It reads back the live 64-bit count with coherent two-word reads, and raises the compare interrupt.

## Interface
- WAIT_STATES, 0, extra APB access cycles before pready (legal 0..3)
- ADDR_W, 12, width of paddr
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- pstrb  in  4  byte strobes
- prdata  out  32  read data; 0 outside the completion cycle
- pready  out  1  transfer complete
- pslverr  out  1  error; valid with pready
- cnt_value  in  64  live counter value
- dbg_mode  in  1  debug-halt qualifier
- timer_en  out  1  counter enable (TCR[0])
- timer_en_h_l  out  1  one-cycle pulse on TCR[0] falling; counter clears
- div_en  out  1  TCR[1]
- div_val  out  4  TCR[11:8]
- halt_req  out  1  THCSR[0]
- tdrl_wr_sel  out  1  one-cycle pulse to load low word
- tdro_wr_sel  out  1  one-cycle pulse to load high word
- tdrl  out  32  low-word load data
- tdro  out  32  high-word load data
- tim_int  out  1  interrupt = int_st & int_en

## Operation
- Register map (word offsets):
  - 0x00 TCR, reset 0x0000_0100.
  - 0x04 TDR0 (cnt[31:0]).
  - 0x08 TDR1 (cnt[63:32]).
  - 0x0C TCMP0, reset 0xFFFF_FFFF.
  - 0x10 TCMP1, reset 0xFFFF_FFFF.
  - 0x14 TIER: bit0 int_en.
  - 0x18 TISR: bit0 int_st, write-1-to-clear.
  - 0x1C THCSR: bit0 halt_req RW; bit1 halt_ack RO, = halt_req & dbg_mode.
  - All unlisted bits read 0.
- Byte strobes: a write updates only the bytes whose pstrb bit is set.
- TDR0/TDR1 writes:
  - Merge the strobed bytes into the corresponding live cnt_value word.
  - Drive the merged word on tdrl or tdro.
  - Pulse the matching wr_sel for one cycle, registered, the cycle after the completion edge.
  - tdrl/tdro hold their last value otherwise.
- Coherent read:
  - A TDR0 read captures cnt_value[63:32] into a shadow register and sets snap_vld.
  - A TDR1 read returns the shadow if snap_vld, else the live value.
  - snap_vld clears on a TDR1 read or on any TDR0/TDR1 write.
- Compare:
  - Registered equality: cnt_value == {TCMP1,TCMP0} sets int_st on the next edge.
  - If a set and a W1C clear occur in the same cycle, the set wins.
- timer_en_h_l: registered, high for exactly one cycle after TCR[0] changes 1→0.
- pslverr conditions:
  - paddr[1:0] != 0.
  - Unmapped offset.
  - TCR write with div_val > 8.
  - On error: no register or strobe changes; prdata = 0.
- APB FSM states IDLE → SETUP (psel & !penable) → ACCESS (psel & penable).
  - ACCESS → IDLE when pready is high and psel drops.
  - ACCESS → SETUP on back-to-back transfers.
  - psel deasserted mid-ACCESS: return to IDLE, no side effects.

## Timing
- Wait counter:
  - Counts in ACCESS.
  - pready = ACCESS & (wcnt == WAIT_STATES), so pready is combinational when WAIT_STATES = 0.
  - wcnt returns to 0 on completion or in IDLE.
- Read/write effects take place on the completion edge (psel & penable & pready).
- prdata and pslverr are valid in the completion cycle.
- Reset values: all outputs 0 except div_val = 1 and pready = 0.
- Reset mid-transfer: abort; no pulses issued after rst_n rises.

## Structure
- Shared package timer_pkg holds:
  - Register offsets, TCR field positions, and the reset constants.
  - DIV_MAX = 8.
  - APB state enum.
- One sub-module is natural: timer_apb_fsm, handling wait states, pready, and the completion strobe.
- The register file, coherent read and compare logic stay in the top module.

## Test plan
- Reset: read TCR → 0x0000_0100; read TCMP0 → 0xFFFF_FFFF; tim_int = 0.
- cnt_value = 0x0000_0001_FFFF_FFFF:
  - Read TDR0 → 0xFFFF_FFFF.
  - cnt_value then moves to 0x0000_0002_0000_0000.
  - Read TDR1 → 0x0000_0001 (shadow).
  - A second TDR1 read → 0x0000_0002.
- Write TDR0 = 0x1234_5678 with pstrb = 4'b0011 while cnt[31:0] = 0xAAAA_AAAA → tdrl = 0xAAAA_5678; one-cycle tdrl_wr_sel.
- TCMP = 5, int_en = 1, count 4→5 → int_st and tim_int high; W1C to TISR in the same cycle as a re-match → int_st stays 1.
- TCR write with div_val = 9 → pslverr = 1, TCR unchanged; read at 0x20 → pslverr, prdata = 0.
- WAIT_STATES = 2: pready rises on the 3rd ACCESS cycle; TCR 1→0 → timer_en_h_l high for exactly one cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Purpose: shared constants, APB state type and byte-merge helper for the timer register front-end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package timer_pkg;

  // Word offsets within the 32-byte register window (paddr[4:0])
  localparam logic [4:0] OFF_TCR   = 5'h00;
  localparam logic [4:0] OFF_TDR0  = 5'h04;
  localparam logic [4:0] OFF_TDR1  = 5'h08;
  localparam logic [4:0] OFF_TCMP0 = 5'h0C;
  localparam logic [4:0] OFF_TCMP1 = 5'h10;
  localparam logic [4:0] OFF_TIER  = 5'h14;
  localparam logic [4:0] OFF_TISR  = 5'h18;
  localparam logic [4:0] OFF_THCSR = 5'h1C;

  // TCR field positions
  localparam int TCR_EN_BIT     = 0;
  localparam int TCR_DIV_EN_BIT = 1;
  localparam int TCR_DIV_LSB    = 8;

  localparam logic [31:0] TCR_RST  = 32'h0000_0100;
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;
  localparam logic [3:0]  DIV_RST  = 4'd1;
  localparam logic [3:0]  DIV_MAX  = 4'd8;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // Replace the bytes of old_w selected by strb with the matching bytes of new_w
  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_apb_fsm.sv
// Purpose: APB phase tracker, wait-state counter and completion strobe.
// Latency: pready in access cycle WAIT_STATES+1 (combinational when WAIT_STATES = 0).
// Backpressure: inserts WAIT_STATES wait cycles; a psel drop in access aborts the transfer.
// Ports: clk, rst_n, psel, penable in; pready (transfer complete), xfer_done (completion strobe) out.
module timer_apb_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic xfer_done
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  // state_q holds the bus phase seen in the previous cycle, so an access
  // phase is only honoured when it follows a setup (or an ongoing wait).
  apb_state_e state_q;
  logic [1:0] wcnt_q;
  logic       access;

  assign access    = psel & penable & (state_q != APB_IDLE);
  assign pready    = access & (wcnt_q == WS);
  assign xfer_done = pready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= APB_IDLE;
      wcnt_q  <= '0;
    end else begin
      if (psel && !penable) begin
        state_q <= APB_SETUP;
        wcnt_q  <= '0;
      end else if (access && !pready) begin
        state_q <= APB_ACCESS;
        wcnt_q  <= wcnt_q + 2'd1;
      end else begin
        // completed, aborted or idle bus
        state_q <= APB_IDLE;
        wcnt_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/timer_apb_regs.sv
// Purpose: APB register file for the 64-bit system timer (control, load strobes, coherent readback, compare irq).
// Latency: reads/writes complete with pready; load strobes and irq status are registered, one cycle later.
// Backpressure: WAIT_STATES wait cycles per transfer via timer_apb_fsm; errors complete with pslverr.
// Ports: APB slave (psel..pslverr), cnt_value/dbg_mode from the counter, counter control and tim_int out.
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [63:0]       cnt_value,
  input  logic              dbg_mode,
  output logic              timer_en,
  output logic              timer_en_h_l,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              halt_req,
  output logic              tdrl_wr_sel,
  output logic              tdro_wr_sel,
  output logic [31:0]       tdrl,
  output logic [31:0]       tdro,
  output logic              tim_int
);

  logic xfer_done;

  timer_apb_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pready   (pready),
    .xfer_done(xfer_done)
  );

  logic        en_q, en_d, div_en_q, div_en_d, h_l_q, h_l_d;
  logic [3:0]  div_q, div_d;
  logic [31:0] tcmp0_q, tcmp0_d, tcmp1_q, tcmp1_d;
  logic        int_en_q, int_en_d, int_st_q, int_st_d, halt_q, halt_d;
  logic [31:0] snap_q, snap_d;
  logic        snap_vld_q, snap_vld_d;
  logic [31:0] tdrl_q, tdrl_d, tdro_q, tdro_d;
  logic        tdrl_sel_q, tdrl_sel_d, tdro_sel_q, tdro_sel_d;

  logic [4:0]  off;
  logic [3:0]  wr_div;
  logic        err, wr_ok, rd_ok, match;
  logic [31:0] rdata;

  assign off    = paddr[4:0];
  // TCR divider value as it would be after this write's byte strobes
  assign wr_div = pstrb[1] ? pwdata[TCR_DIV_LSB +: 4] : div_q;
  // Every aligned word in the 32-byte window is mapped; anything above is not.
  assign err    = (paddr[1:0] != 2'b00) || (|paddr[ADDR_W-1:5]) ||
                  (pwrite && (off == OFF_TCR) && (wr_div > DIV_MAX));
  assign wr_ok  = xfer_done & pwrite & ~err;
  assign rd_ok  = xfer_done & ~pwrite & ~err;
  assign match  = (cnt_value == {tcmp1_q, tcmp0_q});

  always_comb begin
    rdata = '0;
    case (off)
      OFF_TCR:   rdata = {20'b0, div_q, 6'b0, div_en_q, en_q};
      OFF_TDR0:  rdata = cnt_value[31:0];
      OFF_TDR1:  rdata = snap_vld_q ? snap_q : cnt_value[63:32];
      OFF_TCMP0: rdata = tcmp0_q;
      OFF_TCMP1: rdata = tcmp1_q;
      OFF_TIER:  rdata = {31'b0, int_en_q};
      OFF_TISR:  rdata = {31'b0, int_st_q};
      OFF_THCSR: rdata = {30'b0, halt_q & dbg_mode, halt_q};
      default:   rdata = '0;
    endcase
  end

  assign prdata  = rd_ok ? rdata : 32'b0;
  assign pslverr = xfer_done & err;

  always_comb begin
    en_d       = en_q;
    div_en_d   = div_en_q;
    div_d      = div_q;
    tcmp0_d    = tcmp0_q;
    tcmp1_d    = tcmp1_q;
    int_en_d   = int_en_q;
    halt_d     = halt_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    tdrl_d     = tdrl_q;
    tdro_d     = tdro_q;
    tdrl_sel_d = 1'b0;
    tdro_sel_d = 1'b0;
    int_st_d   = int_st_q;

    if (wr_ok) begin
      case (off)
        OFF_TCR: begin
          if (pstrb[0]) begin
            en_d     = pwdata[TCR_EN_BIT];
            div_en_d = pwdata[TCR_DIV_EN_BIT];
          end
          div_d = wr_div;
        end
        OFF_TDR0: begin
          tdrl_d     = strb_merge(cnt_value[31:0], pwdata, pstrb);
          tdrl_sel_d = 1'b1;
          snap_vld_d = 1'b0;
        end
        OFF_TDR1: begin
          tdro_d     = strb_merge(cnt_value[63:32], pwdata, pstrb);
          tdro_sel_d = 1'b1;
          snap_vld_d = 1'b0;
        end
        OFF_TCMP0: tcmp0_d = strb_merge(tcmp0_q, pwdata, pstrb);
        OFF_TCMP1: tcmp1_d = strb_merge(tcmp1_q, pwdata, pstrb);
        OFF_TIER:  if (pstrb[0]) int_en_d = pwdata[0];
        OFF_TISR:  if (pstrb[0] && pwdata[0]) int_st_d = 1'b0;
        OFF_THCSR: if (pstrb[0]) halt_d = pwdata[0];
        default: ;
      endcase
    end

    // Reading the low word freezes the high word so the pair is coherent.
    if (rd_ok && off == OFF_TDR0) begin
      snap_d     = cnt_value[63:32];
      snap_vld_d = 1'b1;
    end else if (rd_ok && off == OFF_TDR1) begin
      snap_vld_d = 1'b0;
    end

    // A compare hit overrides a simultaneous W1C clear.
    if (match) int_st_d = 1'b1;

    h_l_d = en_q & ~en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= TCR_RST[TCR_EN_BIT];
      div_en_q   <= TCR_RST[TCR_DIV_EN_BIT];
      div_q      <= DIV_RST;
      h_l_q      <= 1'b0;
      tcmp0_q    <= TCMP_RST;
      tcmp1_q    <= TCMP_RST;
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
      halt_q     <= 1'b0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      tdrl_q     <= '0;
      tdro_q     <= '0;
      tdrl_sel_q <= 1'b0;
      tdro_sel_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      div_en_q   <= div_en_d;
      div_q      <= div_d;
      h_l_q      <= h_l_d;
      tcmp0_q    <= tcmp0_d;
      tcmp1_q    <= tcmp1_d;
      int_en_q   <= int_en_d;
      int_st_q   <= int_st_d;
      halt_q     <= halt_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      tdrl_q     <= tdrl_d;
      tdro_q     <= tdro_d;
      tdrl_sel_q <= tdrl_sel_d;
      tdro_sel_q <= tdro_sel_d;
    end
  end

  assign timer_en     = en_q;
  assign timer_en_h_l = h_l_q;
  assign div_en       = div_en_q;
  assign div_val      = div_q;
  assign halt_req     = halt_q;
  assign tdrl_wr_sel  = tdrl_sel_q;
  assign tdro_wr_sel  = tdro_sel_q;
  assign tdrl         = tdrl_q;
  assign tdro         = tdro_q;
  assign tim_int      = int_st_q & int_en_q;

endmodule
